// File: rtl/tristan_mem_pkg.sv
// Shared types for the instruction/data memory arbiter: request source IDs,
// arbiter states and the address-phase bundle presented to the SRAM.
package tristan_mem_pkg;

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } mem_src_e;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_addr_phase_t;

    localparam logic [3:0] INSTR_BE = 4'hF;

    // Picks the port to present this cycle; only meaningful when at least one port requests.
    function automatic mem_src_e pick_source(
        input logic     instr_req,
        input logic     data_req,
        input mem_src_e last_grant,
        input bit       data_prio
    );
        if (instr_req && !data_req) return SRC_INSTR;
        if (data_req && !instr_req) return SRC_DATA;
        if (data_prio)              return SRC_DATA;
        return (last_grant == SRC_DATA) ? SRC_INSTR : SRC_DATA;
    endfunction

endpackage

// File: rtl/mem_src_fifo.sv
// In-order FIFO of source IDs for accepted address phases; the head names the
// port that owns the next memory response.
module mem_src_fifo
    import tristan_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push,
    input  mem_src_e push_src,
    input  logic     pop,
    output mem_src_e head,
    output logic     empty,
    output logic     full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    mem_src_e               slots [DEPTH];
    logic     [PTR_W-1:0]   wr_ptr;
    logic     [PTR_W-1:0]   rd_ptr;
    logic     [CNT_W-1:0]   count;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // NOTE: storage is not reset; entries are only read once the count says
    // they were written, so a reset here would just cost flops.
    always_ff @(posedge clk_i) begin
        if (push) slots[wr_ptr] <= push_src;
    end

    // A push into a full FIFO is only issued together with a pop, so the slot
    // at rd_ptr is read (old value) and overwritten in the same cycle.
    assign head  = slots[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/obi_mem_arbiter.sv
// Shares one single-ported OBI memory between the instruction and data ports,
// holding a stalled grant stable and routing in-order responses by source ID.
module obi_mem_arbiter
    import tristan_mem_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter bit          DATA_PRIO       = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    input  logic [31:0] instr_addr_i,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,

    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,

    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,

    output logic        protocol_err_o
);

    arb_state_e      state;
    mem_src_e        locked_sel;
    mem_src_e        last_grant;
    mem_src_e        sel;
    mem_src_e        head;
    mem_addr_phase_t addr_phase;
    logic            fifo_empty;
    logic            fifo_full;
    logic            any_req;
    logic            can_issue;
    logic            handshake;
    logic            pop;
    logic            protocol_err;

    // A response in the same cycle frees a slot, so a full FIFO can still accept.
    assign pop       = mem_rvalid_i && !fifo_empty;
    assign can_issue = !fifo_full || pop;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        sel        = pick_source(instr_req_i, data_req_i, last_grant, DATA_PRIO);
        any_req    = instr_req_i || data_req_i;
        addr_phase = '0;
        if (state == ARB_LOCKED) begin
            sel     = locked_sel;
            any_req = 1'b1;
        end
        if (any_req) begin
            if (sel == SRC_INSTR) begin
                addr_phase.addr  = instr_addr_i;
                addr_phase.we    = 1'b0;
                addr_phase.be    = INSTR_BE;
                addr_phase.wdata = '0;
            end else begin
                addr_phase.addr  = data_addr_i;
                addr_phase.we    = data_we_i;
                addr_phase.be    = data_be_i;
                addr_phase.wdata = data_wdata_i;
            end
        end
    end

    assign mem_req_o   = any_req && can_issue;
    assign handshake   = mem_req_o && mem_gnt_i;
    assign mem_addr_o  = addr_phase.addr;
    assign mem_we_o    = addr_phase.we;
    assign mem_be_o    = addr_phase.be;
    assign mem_wdata_o = addr_phase.wdata;

    assign instr_gnt_o = handshake && (sel == SRC_INSTR);
    assign data_gnt_o  = handshake && (sel == SRC_DATA);

    assign instr_rvalid_o = pop && (head == SRC_INSTR);
    assign data_rvalid_o  = pop && (head == SRC_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    assign protocol_err_o = protocol_err;

    // A stalled request is frozen until the memory takes it; a full FIFO keeps
    // the lock because no handshake can happen.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= ARB_IDLE;
            locked_sel <= SRC_INSTR;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (mem_req_o && !mem_gnt_i) begin
                        state      <= ARB_LOCKED;
                        locked_sel <= sel;
                    end
                end
                ARB_LOCKED: begin
                    if (handshake) state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant   <= SRC_DATA;
            protocol_err <= 1'b0;
        end else begin
            if (handshake) last_grant <= sel;
            if (mem_rvalid_i && fifo_empty) protocol_err <= 1'b1;
        end
    end

    mem_src_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_src_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push     (handshake),
        .push_src (sel),
        .pop      (pop),
        .head     (head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed bench for obi_mem_arbiter: a round-robin instance and a data-priority
// instance share stimulus; the bench plays the memory cycle by cycle.
module tb_obi_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        data_req_i;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    logic        instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o;
    logic [31:0] instr_rdata_o, data_rdata_o;
    logic        mem_req_o, mem_we_o, protocol_err_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;

    logic        p_instr_gnt_o, p_instr_rvalid_o, p_data_gnt_o, p_data_rvalid_o;
    logic [31:0] p_instr_rdata_o, p_data_rdata_o;
    logic        p_mem_req_o, p_mem_we_o, p_protocol_err_o;
    logic [31:0] p_mem_addr_o, p_mem_wdata_o;
    logic [3:0]  p_mem_be_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    obi_mem_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIO(1'b0)) dut (
        .clk_i (clk_i), .rst_ni (rst_ni),
        .instr_req_i (instr_req_i), .instr_gnt_o (instr_gnt_o), .instr_addr_i (instr_addr_i),
        .instr_rvalid_o (instr_rvalid_o), .instr_rdata_o (instr_rdata_o),
        .data_req_i (data_req_i), .data_gnt_o (data_gnt_o), .data_addr_i (data_addr_i),
        .data_we_i (data_we_i), .data_be_i (data_be_i), .data_wdata_i (data_wdata_i),
        .data_rvalid_o (data_rvalid_o), .data_rdata_o (data_rdata_o),
        .mem_req_o (mem_req_o), .mem_gnt_i (mem_gnt_i), .mem_addr_o (mem_addr_o),
        .mem_we_o (mem_we_o), .mem_be_o (mem_be_o), .mem_wdata_o (mem_wdata_o),
        .mem_rvalid_i (mem_rvalid_i), .mem_rdata_i (mem_rdata_i),
        .protocol_err_o (protocol_err_o)
    );

    obi_mem_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIO(1'b1)) dut_prio (
        .clk_i (clk_i), .rst_ni (rst_ni),
        .instr_req_i (instr_req_i), .instr_gnt_o (p_instr_gnt_o), .instr_addr_i (instr_addr_i),
        .instr_rvalid_o (p_instr_rvalid_o), .instr_rdata_o (p_instr_rdata_o),
        .data_req_i (data_req_i), .data_gnt_o (p_data_gnt_o), .data_addr_i (data_addr_i),
        .data_we_i (data_we_i), .data_be_i (data_be_i), .data_wdata_i (data_wdata_i),
        .data_rvalid_o (p_data_rvalid_o), .data_rdata_o (p_data_rdata_o),
        .mem_req_o (p_mem_req_o), .mem_gnt_i (mem_gnt_i), .mem_addr_o (p_mem_addr_o),
        .mem_we_o (p_mem_we_o), .mem_be_o (p_mem_be_o), .mem_wdata_o (p_mem_wdata_o),
        .mem_rvalid_i (mem_rvalid_i), .mem_rdata_i (mem_rdata_i),
        .protocol_err_o (p_protocol_err_o)
    );

    // Flag order everywhere: {mem_req, instr_gnt, data_gnt, instr_rvalid, data_rvalid}
    function automatic logic [4:0] dut_flags();
        return {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o};
    endfunction

    function automatic logic [4:0] prio_flags();
        return {p_mem_req_o, p_instr_gnt_o, p_data_gnt_o, p_instr_rvalid_o, p_data_rvalid_o};
    endfunction

    // Stimulus order: {instr_req, data_req, mem_gnt, mem_rvalid}
    task automatic drive(input logic [3:0] v);
        {instr_req_i, data_req_i, mem_gnt_i, mem_rvalid_i} = v;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni       = 1'b0;
        drive(4'b0000);
        instr_addr_i = '0;
        data_addr_i  = '0;
        data_we_i    = 1'b0;
        data_be_i    = '0;
        data_wdata_i = '0;
        mem_rdata_i  = '0;
        next_cycle();
        next_cycle();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_ni = 1'b0;
        #2;
        n_checks++;
        if ({dut_flags(), protocol_err_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000000", {dut_flags(), protocol_err_o});
        end
        n_checks++;
        if ({mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o} !== 69'b0) begin
            n_fail++;
            $display("FAIL reset_addr_phase: addr=%h we=%b be=%h wdata=%h expected all zero",
                     mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o);
        end
        next_cycle();
        rst_ni = 1'b1;
    endtask

    task automatic test_single_instr();
        do_reset();
        instr_addr_i = 32'h0000_0100;
        drive(4'b1010);
        #1;
        n_checks++;
        if (dut_flags() !== 5'b11000) begin
            n_fail++;
            $display("FAIL single_gnt: flags=%b expected 11000", dut_flags());
        end
        n_checks++;
        if ({mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o} !== {32'h100, 1'b0, 4'hF, 32'h0}) begin
            n_fail++;
            $display("FAIL single_addr_phase: addr=%h we=%b be=%h wdata=%h expected 100/0/f/0",
                     mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o);
        end
        next_cycle();
        drive(4'b0001);
        mem_rdata_i = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (dut_flags() !== 5'b00010) begin
            n_fail++;
            $display("FAIL single_rvalid: flags=%b expected 00010", dut_flags());
        end
        n_checks++;
        if (instr_rdata_o !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL single_rdata: got %h expected deadbeef", instr_rdata_o);
        end
        next_cycle();
        drive(4'b0000);
    endtask

    task automatic test_round_robin();
        logic [3:0]  stim [5];
        logic [4:0]  exp_flags [5];
        logic [31:0] exp_addr [4];
        stim      = '{4'b1110, 4'b1111, 4'b1111, 4'b1111, 4'b0001};
        exp_flags = '{5'b11000, 5'b10110, 5'b11001, 5'b10110, 5'b00001};
        exp_addr  = '{32'h200, 32'h300, 32'h200, 32'h300};
        do_reset();
        instr_addr_i = 32'h200;
        data_addr_i  = 32'h300;
        for (int c = 0; c < 5; c++) begin
            drive(stim[c]);
            #1;
            n_checks++;
            if (dut_flags() !== exp_flags[c]) begin
                n_fail++;
                $display("FAIL rr_flags cycle %0d: got %b expected %b", c, dut_flags(), exp_flags[c]);
            end
            if (c < 4) begin
                n_checks++;
                if (mem_addr_o !== exp_addr[c]) begin
                    n_fail++;
                    $display("FAIL rr_addr cycle %0d: got %h expected %h", c, mem_addr_o, exp_addr[c]);
                end
            end
            next_cycle();
        end
        drive(4'b0000);
    endtask

    task automatic test_data_prio();
        logic [3:0] stim [5];
        logic [4:0] exp_flags [5];
        stim      = '{4'b1110, 4'b1111, 4'b1111, 4'b1011, 4'b0001};
        exp_flags = '{5'b10100, 5'b10101, 5'b10101, 5'b11001, 5'b00010};
        do_reset();
        instr_addr_i = 32'h600;
        data_addr_i  = 32'h700;
        for (int c = 0; c < 5; c++) begin
            drive(stim[c]);
            #1;
            n_checks++;
            if (prio_flags() !== exp_flags[c]) begin
                n_fail++;
                $display("FAIL prio_flags cycle %0d: got %b expected %b", c, prio_flags(), exp_flags[c]);
            end
            next_cycle();
        end
        drive(4'b0000);
    endtask

    task automatic test_lock_hold();
        logic [3:0]  stim [7];
        logic [4:0]  exp_flags [7];
        logic [31:0] exp_addr [5];
        stim      = '{4'b1000, 4'b1100, 4'b1100, 4'b1110, 4'b0110, 4'b0001, 4'b0001};
        exp_flags = '{5'b10000, 5'b10000, 5'b10000, 5'b11000, 5'b10100, 5'b00010, 5'b00001};
        exp_addr  = '{32'h400, 32'h400, 32'h400, 32'h400, 32'h500};
        do_reset();
        instr_addr_i = 32'h400;
        data_addr_i  = 32'h500;
        data_we_i    = 1'b1;
        data_be_i    = 4'b0011;
        data_wdata_i = 32'hCAFE_F00D;
        for (int c = 0; c < 7; c++) begin
            drive(stim[c]);
            #1;
            n_checks++;
            if (dut_flags() !== exp_flags[c]) begin
                n_fail++;
                $display("FAIL lock_flags cycle %0d: got %b expected %b", c, dut_flags(), exp_flags[c]);
            end
            if (c < 5) begin
                n_checks++;
                if (mem_addr_o !== exp_addr[c]) begin
                    n_fail++;
                    $display("FAIL lock_addr cycle %0d: got %h expected %h", c, mem_addr_o, exp_addr[c]);
                end
            end
            if (c == 2) begin
                n_checks++;
                if (mem_we_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lock_we: got %b expected 0", mem_we_o);
                end
            end
            if (c == 4) begin
                n_checks++;
                if ({mem_we_o, mem_be_o, mem_wdata_o} !== {1'b1, 4'b0011, 32'hCAFE_F00D}) begin
                    n_fail++;
                    $display("FAIL lock_data_phase: we=%b be=%b wdata=%h expected 1/0011/cafef00d",
                             mem_we_o, mem_be_o, mem_wdata_o);
                end
            end
            next_cycle();
        end
        drive(4'b0000);
        data_we_i = 1'b0;
    endtask

    task automatic test_outstanding_limit();
        logic [3:0] stim [9];
        logic [4:0] exp_flags [9];
        stim      = '{4'b1010, 4'b0110, 4'b1010, 4'b1011, 4'b0100,
                      4'b0111, 4'b0001, 4'b0001, 4'b0000};
        exp_flags = '{5'b11000, 5'b10100, 5'b00000, 5'b11010, 5'b00000,
                      5'b10101, 5'b00010, 5'b00001, 5'b00000};
        do_reset();
        instr_addr_i = 32'h800;
        data_addr_i  = 32'h900;
        for (int c = 0; c < 9; c++) begin
            drive(stim[c]);
            mem_rdata_i = 32'h11 + 32'(c);
            #1;
            n_checks++;
            if (dut_flags() !== exp_flags[c]) begin
                n_fail++;
                $display("FAIL limit_flags cycle %0d: got %b expected %b", c, dut_flags(), exp_flags[c]);
            end
            if (c == 3) begin
                n_checks++;
                if (instr_rdata_o !== 32'h14) begin
                    n_fail++;
                    $display("FAIL limit_rdata: got %h expected 14", instr_rdata_o);
                end
            end
            next_cycle();
        end
        n_checks++;
        if (protocol_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL limit_no_err: got %b expected 0", protocol_err_o);
        end
        drive(4'b0000);
    endtask

    task automatic test_protocol_err();
        do_reset();
        drive(4'b0001);
        mem_rdata_i = 32'h5555_AAAA;
        #1;
        n_checks++;
        if ({dut_flags(), protocol_err_o} !== 6'b000000) begin
            n_fail++;
            $display("FAIL err_stray_rvalid: flags+err=%b expected 000000", {dut_flags(), protocol_err_o});
        end
        next_cycle();
        drive(4'b0000);
        #1;
        n_checks++;
        if (protocol_err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set: got %b expected 1", protocol_err_o);
        end
        next_cycle();
        n_checks++;
        if (protocol_err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %b expected 1", protocol_err_o);
        end
        rst_ni = 1'b0;
        #2;
        rst_ni = 1'b1;
        #1;
        n_checks++;
        if (protocol_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: got %b expected 0", protocol_err_o);
        end
    endtask

    initial begin
        test_reset();
        test_single_instr();
        test_round_robin();
        test_data_prio();
        test_lock_hold();
        test_outstanding_limit();
        test_protocol_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
